// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide storage plus a request/ready access controller for the
// CPU, with a programmable wait-state count and a loader port usable in IDLE.
module mem_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic              busy,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              accept;

    // Storage array; never cleared by reset.
    logic [DATA_W-1:0] mem [DEPTH];

    // Attributes of the access heading into RESP: straight from the CPU pins
    // when IDLE jumps directly to RESP (no wait states), otherwise latched.
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic              enter_resp;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Unsigned address compare against the implemented depth.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (32'(a) < 32'(DEPTH));
    endfunction

    // Next-state logic: loader beats the CPU in IDLE; WAIT runs WAIT_STATES cycles.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!ld_valid && cpu_req) begin
                    accept = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_next = WAIT;
                        cnt_next   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Select the attributes of the access about to enter RESP.
    always_comb begin
        acc_we     = (state_reg == IDLE) ? cpu_we   : we_reg;
        acc_addr   = (state_reg == IDLE) ? cpu_addr : addr_reg;
        enter_resp = (state_next == RESP);
    end

    // State, wait counter and the latched request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                we_reg    <= cpu_we;
                addr_reg  <= cpu_addr;
                wdata_reg <= cpu_wdata;
            end
        end
    end

    // Registered outputs, set on the edge entering RESP so they are valid during it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            busy      <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            cpu_ready <= enter_resp;
            cpu_err   <= enter_resp && !in_range(acc_addr);
            busy      <= (state_next != IDLE);
            if (enter_resp && !acc_we) begin
                cpu_rdata <= in_range(acc_addr) ? mem[acc_addr[IDX_W-1:0]] : '0;
            end
        end
    end

    // Single write port: loader in IDLE, or a CPU store committing as RESP ends.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_reg[IDX_W-1:0];
        mem_wdata = wdata_reg;
        if (state_reg == IDLE) begin
            mem_we    = ld_valid && in_range(ld_addr);
            mem_waddr = ld_addr[IDX_W-1:0];
            mem_wdata = ld_data;
        end else if (state_reg == RESP) begin
            mem_we = we_reg && in_range(addr_reg);
        end
    end

    // Array write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign ld_ready = (state_reg == IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: three instances (WS=1/DEPTH=128, WS=0/DEPTH=256,
// WS=15/DEPTH=256) exercised by a directed vector table plus hand sequences.
module tb_mem_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_s   [3];
    logic       we_s    [3];
    logic [7:0] addr_s  [3];
    logic [7:0] wdata_s [3];
    logic       ready_s [3];
    logic [7:0] rdata_s [3];
    logic       err_s   [3];
    logic       busy_s  [3];
    logic       ldv_s   [3];
    logic [7:0] lda_s   [3];
    logic [7:0] ldd_s   [3];
    logic       ldr_s   [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        mem_ctrl #(
            .ADDR_W     (8),
            .DATA_W     (8),
            .DEPTH      ((gi == 0) ? 128 : 256),
            .WAIT_STATES((gi == 0) ? 1 : ((gi == 1) ? 0 : 15))
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .cpu_req  (req_s[gi]),
            .cpu_we   (we_s[gi]),
            .cpu_addr (addr_s[gi]),
            .cpu_wdata(wdata_s[gi]),
            .cpu_ready(ready_s[gi]),
            .cpu_rdata(rdata_s[gi]),
            .cpu_err  (err_s[gi]),
            .busy     (busy_s[gi]),
            .ld_valid (ldv_s[gi]),
            .ld_addr  (lda_s[gi]),
            .ld_data  (ldd_s[gi]),
            .ld_ready (ldr_s[gi])
        );
    end

    typedef struct {
        int         k;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic       exp_err;
        int         exp_lat;
        int         exp_busy;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end else begin
            $display("ok   %s = %0h", nm, act);
        end
    endtask

    task automatic loader(input int k, input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        ldv_s[k] = 1'b1; lda_s[k] = a; ldd_s[k] = d;
        @(posedge clk); #1;
        ldv_s[k] = 1'b0;
        $display("load inst%0d mem[%02h]=%02h", k, a, d);
    endtask

    // One CPU access; req is dropped right after acceptance. Latency counts
    // falling edges after the acceptance edge up to the one seeing cpu_ready.
    task automatic access(input int k, input logic w, input logic [7:0] a,
                          input logic [7:0] d, output int lat, output int bcnt,
                          output logic [7:0] rd, output logic er);
        bit got;
        got = 1'b0; lat = 0; bcnt = 0; rd = '0; er = 1'b0;
        @(posedge clk); #1;
        req_s[k] = 1'b1; we_s[k] = w; addr_s[k] = a; wdata_s[k] = d;
        @(posedge clk); #1;
        req_s[k] = 1'b0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            if (busy_s[k]) bcnt++;
            if (ready_s[k]) begin
                got = 1'b1; lat = i; rd = rdata_s[k]; er = err_s[k];
            end
        end
        @(negedge clk);
        chk($sformatf("inst%0d_ready_one_cycle", k), 32'(ready_s[k]), 32'd0);
        chk($sformatf("inst%0d_busy_cleared", k), 32'(busy_s[k]), 32'd0);
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int lat, bcnt;
        logic [7:0] rd;
        logic er;
        access(v.k, v.we, v.addr, v.wdata, lat, bcnt, rd, er);
        $display("txn %s inst%0d we=%0d addr=%02h wdata=%02h -> rdata=%02h err=%0d lat=%0d busy=%0d",
                 nm, v.k, v.we, v.addr, v.wdata, rd, er, lat, bcnt);
        chk({nm, "_rdata"}, 32'(rd), 32'(v.exp_rdata));
        chk({nm, "_err"},   32'(er), 32'(v.exp_err));
        chk({nm, "_lat"},   32'(lat), 32'(v.exp_lat));
        chk({nm, "_busy"},  32'(bcnt), 32'(v.exp_busy));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [12];
        vec_t v;
        int   t [3];
        int   nt, wide;
        logic prev;

        vecs[0]  = '{0, 1'b0, 8'h10, 8'h00, 8'h4A, 1'b0, 2, 2};
        vecs[1]  = '{1, 1'b1, 8'h7F, 8'hC3, 8'h00, 1'b0, 1, 1};
        vecs[2]  = '{1, 1'b0, 8'h7F, 8'h00, 8'hC3, 1'b0, 1, 1};
        vecs[3]  = '{1, 1'b1, 8'h7F, 8'h3C, 8'hC3, 1'b0, 1, 1};
        vecs[4]  = '{1, 1'b0, 8'h7F, 8'h00, 8'h3C, 1'b0, 1, 1};
        vecs[5]  = '{0, 1'b1, 8'h90, 8'h55, 8'h4A, 1'b1, 2, 2};
        vecs[6]  = '{0, 1'b0, 8'h10, 8'h00, 8'h4A, 1'b0, 2, 2};
        vecs[7]  = '{0, 1'b0, 8'h90, 8'h00, 8'h00, 1'b1, 2, 2};
        vecs[8]  = '{0, 1'b1, 8'h7F, 8'h99, 8'h00, 1'b0, 2, 2};
        vecs[9]  = '{0, 1'b0, 8'h7F, 8'h00, 8'h99, 1'b0, 2, 2};
        vecs[10] = '{0, 1'b0, 8'h80, 8'h00, 8'h00, 1'b1, 2, 2};
        vecs[11] = '{2, 1'b0, 8'h05, 8'h00, 8'hE7, 1'b0, 16, 16};

        for (int k = 0; k < 3; k++) begin
            req_s[k] = 1'b0; we_s[k] = 1'b0; addr_s[k] = '0; wdata_s[k] = '0;
            ldv_s[k] = 1'b0; lda_s[k] = '0; ldd_s[k] = '0;
        end

        // Reset state.
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_inst%0d_ready", k), 32'(ready_s[k]), 32'd0);
            chk($sformatf("rst_inst%0d_busy", k),  32'(busy_s[k]),  32'd0);
            chk($sformatf("rst_inst%0d_err", k),   32'(err_s[k]),   32'd0);
            chk($sformatf("rst_inst%0d_rdata", k), 32'(rdata_s[k]), 32'd0);
            chk($sformatf("rst_inst%0d_ldready", k), 32'(ldr_s[k]), 32'd1);
        end
        rst = 1'b1;

        // Preloads; the 0x90 write on the 128-deep instance must be dropped.
        loader(0, 8'h10, 8'h4A);
        loader(0, 8'h90, 8'hAA);
        loader(2, 8'h05, 8'hE7);
        loader(2, 8'h06, 8'h12);

        for (int i = 0; i < 12; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Loader and CPU request in the same IDLE cycle: loader first.
        @(posedge clk); #1;
        ldv_s[1] = 1'b1; lda_s[1] = 8'h20; ldd_s[1] = 8'h11;
        req_s[1] = 1'b1; we_s[1] = 1'b0; addr_s[1] = 8'h20;
        @(negedge clk);
        chk("prio_ldready_idle", 32'(ldr_s[1]), 32'd1);
        @(posedge clk); #1;
        ldv_s[1] = 1'b0;
        @(negedge clk);
        chk("prio_no_ready_yet", 32'(ready_s[1]), 32'd0);
        chk("prio_not_busy_yet", 32'(busy_s[1]), 32'd0);
        @(posedge clk); #1;
        req_s[1] = 1'b0;
        @(negedge clk);
        chk("prio_ready", 32'(ready_s[1]), 32'd1);
        chk("prio_rdata", 32'(rdata_s[1]), 32'h11);
        $display("txn prio inst1 ready=%0d rdata=%02h", ready_s[1], rdata_s[1]);

        // Back-to-back loads with req held high on the 15-wait-state instance.
        @(posedge clk); #1;
        req_s[2] = 1'b1; we_s[2] = 1'b0; addr_s[2] = 8'h05;
        nt = 0; wide = 0; prev = 1'b0;
        for (int i = 0; i < 72; i++) begin
            @(negedge clk);
            if (ready_s[2]) begin
                if (nt < 3) t[nt] = i;
                nt++;
                if (prev) wide++;
            end
            prev = ready_s[2];
        end
        req_s[2] = 1'b0;
        if (nt < 3) begin
            for (int j = nt; j < 3; j++) t[j] = -100 * (j + 1);
        end
        $display("txn maxwait pulses=%0d t0=%0d t1=%0d t2=%0d", nt, t[0], t[1], t[2]);
        chk("maxwait_pulses_seen", 32'(nt >= 3), 32'd1);
        chk("maxwait_period_a", 32'(t[1] - t[0]), 32'd17);
        chk("maxwait_period_b", 32'(t[2] - t[1]), 32'd17);
        chk("maxwait_wide_pulses", 32'(wide), 32'd0);
        chk("maxwait_rdata", 32'(rdata_s[2]), 32'hE7);
        repeat (20) @(negedge clk);
        chk("maxwait_idle_after", 32'(busy_s[2]), 32'd0);

        // Reset in the middle of WAIT drops the pending store.
        @(posedge clk); #1;
        req_s[2] = 1'b1; we_s[2] = 1'b1; addr_s[2] = 8'h06; wdata_s[2] = 8'h77;
        @(posedge clk); #1;
        req_s[2] = 1'b0;
        repeat (5) @(negedge clk);
        chk("midwait_busy", 32'(busy_s[2]), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("midrst_ready", 32'(ready_s[2]), 32'd0);
        chk("midrst_busy", 32'(busy_s[2]), 32'd0);
        chk("midrst_ldready", 32'(ldr_s[2]), 32'd1);
        chk("midrst_rdata_inst1", 32'(rdata_s[1]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        chk("postrst_no_ready", 32'(ready_s[2]), 32'd0);
        v = '{2, 1'b0, 8'h06, 8'h00, 8'h12, 1'b0, 16, 16};
        run_vec("store_dropped", v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
